// File: rtl/flag_if.sv
// Bundle carrying the ALU result, flag-update enable, condition mask and opcode
// into the condition-flag block, and its Perform decision back out.
interface flag_if #(
  parameter int unsigned DATA_W = 16
);
  logic [DATA_W-1:0] ALUOut;
  logic              FU;
  logic [2:0]        CC;
  logic [3:0]        Op;
  logic              Perform;

  modport master (
    output ALUOut,
    output FU,
    output CC,
    output Op,
    input  Perform
  );

  modport slave (
    input  ALUOut,
    input  FU,
    input  CC,
    input  Op,
    output Perform
  );
endinterface

// File: rtl/flag.sv
// Condition-flag register {N,Z,P} updated from the ALU result, and the
// branch/predication decision Perform derived from the registered flags.
module flag #(
  parameter int unsigned DATA_W = 16
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  flag_if.slave  bus
);

  localparam logic [3:0] OpLui = 4'b0011;
  localparam logic [3:0] OpCpi = 4'b0111;

  logic [2:0] flags_q;
  logic [2:0] flags_d;
  logic       n_flag;
  logic       z_flag;

  // Flags are computed from the full unextended result width.
  always_comb begin
    n_flag  = bus.ALUOut[DATA_W-1];
    z_flag  = (bus.ALUOut == '0);
    flags_d = flags_q;
    if (bus.FU) begin
      flags_d = {n_flag, z_flag, ~n_flag & ~z_flag};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      flags_q <= 3'b000;
    end else begin
      flags_q <= flags_d;
    end
  end

  // Only registered flags feed Perform, so an update shows up one cycle later.
  always_comb begin
    bus.Perform = 1'b0;
    if ((bus.Op == OpLui) || (bus.Op == OpCpi)) begin
      bus.Perform = 1'b0;
    end else if (bus.CC == 3'b000) begin
      bus.Perform = 1'b1;
    end else begin
      bus.Perform = |(bus.CC & flags_q);
    end
  end

endmodule

// File: tb/tb_flag.sv
// Directed bench for flag: walks the flag register through N, Z, P and reset
// and checks Perform against hand-computed values.
module tb_flag;

  logic clk_i;
  logic rst_ni;
  int   checks;
  int   failures;

  flag_if #(.DATA_W(16)) bus ();

  flag #(.DATA_W(16)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  // Apply CC/Op, let the combinational output settle, then compare.
  task automatic probe(input string tag, input logic [2:0] cc, input logic [3:0] op,
                       input logic exp);
    bus.CC = cc;
    bus.Op = op;
    #1;
    chk(tag, bus.Perform, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst_ni     = 1'b0;
    bus.ALUOut = 16'h0000;
    bus.FU     = 1'b0;
    bus.CC     = 3'b000;
    bus.Op     = 4'b0000;
    tick();

    // Reset state: flags 000.
    probe("rst_cc100", 3'b100, 4'b0000, 1'b0);
    probe("rst_cc111", 3'b111, 4'b0000, 1'b0);
    probe("rst_cc000", 3'b000, 4'b0000, 1'b1);
    probe("rst_cc000_lui", 3'b000, 4'b0011, 1'b0);

    // Release reset with FU=0: flags stay 000.
    rst_ni = 1'b1;
    tick();
    tick();
    probe("post_rst_hold", 3'b111, 4'b0000, 1'b0);

    // Scenario 1: negative result.
    bus.ALUOut = 16'hFFFF;
    bus.FU     = 1'b1;
    probe("same_cycle_invisible", 3'b100, 4'b0000, 1'b0);
    tick();
    bus.FU = 1'b0;
    probe("s1_cc100", 3'b100, 4'b0000, 1'b1);
    probe("s1_cc001", 3'b001, 4'b0000, 1'b0);
    probe("s1_cc111", 3'b111, 4'b0000, 1'b1);
    probe("s1_cc010", 3'b010, 4'b0000, 1'b0);

    // Scenarios 2 and 3: unconditional and lui/cpi override.
    probe("s2_cc000_op1", 3'b000, 4'b0001, 1'b1);
    probe("s3_lui", 3'b111, 4'b0011, 1'b0);
    probe("s3_cpi", 3'b111, 4'b0111, 1'b0);
    probe("s3_op15", 3'b111, 4'b1111, 1'b1);

    // Scenario 4: zero then positive.
    bus.ALUOut = 16'h0000;
    bus.FU     = 1'b1;
    tick();
    bus.FU = 1'b0;
    probe("s4_z_cc010", 3'b010, 4'b0000, 1'b1);
    probe("s4_z_cc101", 3'b101, 4'b0000, 1'b0);
    bus.ALUOut = 16'h0005;
    bus.FU     = 1'b1;
    tick();
    bus.FU = 1'b0;
    probe("s4_p_cc001", 3'b001, 4'b0000, 1'b1);
    probe("s4_p_cc110", 3'b110, 4'b0000, 1'b0);

    // Scenario 5: FU=0 holds across edges despite a negative ALUOut.
    bus.ALUOut = 16'h8000;
    tick();
    tick();
    tick();
    probe("s5_hold_cc001", 3'b001, 4'b0000, 1'b1);
    probe("s5_hold_cc100", 3'b100, 4'b0000, 1'b0);

    // Zero test must see upper bits: 0x0100 is positive, not zero.
    bus.ALUOut = 16'h0100;
    bus.FU     = 1'b1;
    tick();
    bus.FU = 1'b0;
    probe("upper_bit_cc010", 3'b010, 4'b0000, 1'b0);
    probe("upper_bit_cc001", 3'b001, 4'b0000, 1'b1);

    // Scenario 6: set N, then reset mid-cycle.
    bus.ALUOut = 16'h8000;
    bus.FU     = 1'b1;
    tick();
    bus.FU = 1'b0;
    probe("s6_n_cc100", 3'b100, 4'b0000, 1'b1);
    #2;
    rst_ni = 1'b0;
    probe("s6_async_cc100", 3'b100, 4'b0000, 1'b0);
    probe("s6_async_cc000", 3'b000, 4'b0000, 1'b1);
    bus.ALUOut = 16'hFFFF;
    bus.FU     = 1'b1;
    tick();
    tick();
    probe("s6_rst_wins_cc100", 3'b100, 4'b0000, 1'b0);
    probe("s6_rst_wins_cc111", 3'b111, 4'b0000, 1'b0);

    // After release, flags wait for the first FU=1 edge.
    bus.FU = 1'b0;
    rst_ni = 1'b1;
    tick();
    probe("s6_release_hold", 3'b111, 4'b0000, 1'b0);
    bus.FU = 1'b1;
    tick();
    bus.FU = 1'b0;
    probe("s6_reload_cc100", 3'b100, 4'b0000, 1'b1);
    probe("s6_reload_cc011", 3'b011, 4'b0000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
